// File: rtl/elevator_scheduler.sv
// LOOK-policy call scheduler: picks the car's next target floor from latched calls,
// handshakes with the car FSM and returns per-floor clear pulses for served calls.
module elevator_scheduler #(
   parameter int FLOORS  = 8,
   parameter int FLOOR_W = 3
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [FLOORS-1:0]  req_in,
   input  logic [FLOORS-1:0]  req_up,
   input  logic [FLOORS-1:0]  req_down,
   input  logic [FLOOR_W-1:0] cur_floor,
   input  logic               arrive,
   input  logic               door_done,
   output logic               tgt_valid,
   output logic [FLOOR_W-1:0] tgt_floor,
   output logic [1:0]         dir,
   output logic [FLOORS-1:0]  clr_in,
   output logic [FLOORS-1:0]  clr_up,
   output logic [FLOORS-1:0]  clr_down
);

   typedef enum logic [1:0] {ST_IDLE, ST_UP, ST_DOWN, ST_SERVE} state_t;
   typedef enum logic [1:0] {DIR_IDLE = 2'd0, DIR_DOWN = 2'd1, DIR_UP = 2'd2} dir_t;

   state_t              state, state_n;
   dir_t                dir_q, dir_n;
   logic                tgt_valid_n;
   logic [FLOOR_W-1:0]  tgt_floor_n;
   logic [FLOORS-1:0]   clr_in_n, clr_up_n, clr_down_n;

   logic [FLOORS-1:0]   pend, above, below;
   logic                here, any_above, any_below, arrive_ok;
   logic                up_near_vld, dn_near_vld;
   logic [FLOOR_W-1:0]  up_near, up_far, dn_near, dn_far, up_tgt, dn_tgt;

   assign pend = req_in | req_up | req_down;

   // NOTE: every combinational output gets a default before any branch, so no latch is inferred.
   always_comb begin
      above = '0;
      below = '0;
      for (int i = 0; i < FLOORS; i++) begin
         above[i] = pend[i] && (i > int'(cur_floor));
         below[i] = pend[i] && (i < int'(cur_floor));
      end
   end

   assign here      = pend[cur_floor];
   assign any_above = |above;
   assign any_below = |below;

   // Ascending scan: the last hit is the highest matching floor.
   always_comb begin
      up_far      = '0;
      dn_near     = '0;
      dn_near_vld = 1'b0;
      for (int i = 0; i < FLOORS; i++) begin
         if (above[i] && req_down[i])
            up_far = FLOOR_W'(i);
         if (below[i] && (req_in[i] || req_down[i])) begin
            dn_near     = FLOOR_W'(i);
            dn_near_vld = 1'b1;
         end
      end
   end

   // Descending scan: the last hit is the lowest matching floor.
   always_comb begin
      up_near     = '0;
      up_near_vld = 1'b0;
      dn_far      = '0;
      for (int i = FLOORS - 1; i >= 0; i--) begin
         if (above[i] && (req_in[i] || req_up[i])) begin
            up_near     = FLOOR_W'(i);
            up_near_vld = 1'b1;
         end
         if (below[i] && req_up[i])
            dn_far = FLOOR_W'(i);
      end
   end

   // Calls travelling our way come first; otherwise the furthest opposite call is the turnaround.
   assign up_tgt = up_near_vld ? up_near : up_far;
   assign dn_tgt = dn_near_vld ? dn_near : dn_far;

   assign arrive_ok = arrive && tgt_valid && (cur_floor == tgt_floor);

   function automatic dir_t pick_dir(input dir_t d, input logic a, input logic b);
      dir_t r;
      r = DIR_IDLE;
      case (d)
         DIR_UP:   r = a ? DIR_UP   : (b ? DIR_DOWN : DIR_IDLE);
         DIR_DOWN: r = b ? DIR_DOWN : (a ? DIR_UP   : DIR_IDLE);
         default:  r = a ? DIR_UP   : (b ? DIR_DOWN : DIR_IDLE);
      endcase
      return r;
   endfunction

   always_comb begin
      state_n     = state;
      dir_n       = dir_q;
      tgt_valid_n = tgt_valid;
      tgt_floor_n = tgt_floor;
      clr_in_n    = '0;
      clr_up_n    = '0;
      clr_down_n  = '0;

      unique case (state)
         ST_IDLE: begin
            if (arrive_ok) begin
               state_n     = ST_SERVE;
               tgt_valid_n = 1'b0;
               dir_n       = pick_dir(DIR_IDLE, any_above, any_below);
            end else if (here) begin
               tgt_valid_n = 1'b1;
               tgt_floor_n = cur_floor;
               dir_n       = DIR_IDLE;
            end else if (any_above) begin
               state_n     = ST_UP;
               tgt_valid_n = 1'b1;
               tgt_floor_n = up_tgt;
               dir_n       = DIR_UP;
            end else if (any_below) begin
               state_n     = ST_DOWN;
               tgt_valid_n = 1'b1;
               tgt_floor_n = dn_tgt;
               dir_n       = DIR_DOWN;
            end else begin
               tgt_valid_n = 1'b0;
               dir_n       = DIR_IDLE;
            end
         end

         ST_UP: begin
            if (arrive_ok) begin
               state_n     = ST_SERVE;
               tgt_valid_n = 1'b0;
               dir_n       = pick_dir(dir_q, any_above, any_below);
            end else if (!any_above) begin
               state_n     = ST_IDLE;
               tgt_valid_n = 1'b0;
               dir_n       = DIR_IDLE;
            end else begin
               tgt_valid_n = 1'b1;
               tgt_floor_n = up_tgt;
               dir_n       = DIR_UP;
            end
         end

         ST_DOWN: begin
            if (arrive_ok) begin
               state_n     = ST_SERVE;
               tgt_valid_n = 1'b0;
               dir_n       = pick_dir(dir_q, any_above, any_below);
            end else if (!any_below) begin
               state_n     = ST_IDLE;
               tgt_valid_n = 1'b0;
               dir_n       = DIR_IDLE;
            end else begin
               tgt_valid_n = 1'b1;
               tgt_floor_n = dn_tgt;
               dir_n       = DIR_DOWN;
            end
         end

         ST_SERVE: begin
            // tgt_valid is low here, so a coincident arrive can never pre-empt door_done.
            if (door_done) begin
               dir_n = pick_dir(dir_q, any_above, any_below);
               case (dir_n)
                  DIR_UP: begin
                     state_n     = ST_UP;
                     tgt_valid_n = 1'b1;
                     tgt_floor_n = up_tgt;
                  end
                  DIR_DOWN: begin
                     state_n     = ST_DOWN;
                     tgt_valid_n = 1'b1;
                     tgt_floor_n = dn_tgt;
                  end
                  default: begin
                     state_n     = ST_IDLE;
                     tgt_valid_n = 1'b0;
                  end
               endcase
            end
         end

         default: begin
            state_n     = ST_IDLE;
            tgt_valid_n = 1'b0;
            dir_n       = DIR_IDLE;
         end
      endcase

      // Hall calls are only absorbed when the car will leave in their direction (or has none).
      if (state_n == ST_SERVE) begin
         clr_in_n[cur_floor]   = req_in[cur_floor];
         clr_up_n[cur_floor]   = req_up[cur_floor] && (dir_n != DIR_DOWN);
         clr_down_n[cur_floor] = req_down[cur_floor] && (dir_n != DIR_UP);
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= ST_IDLE;
         dir_q     <= DIR_IDLE;
         tgt_valid <= 1'b0;
         tgt_floor <= '0;
         clr_in    <= '0;
         clr_up    <= '0;
         clr_down  <= '0;
      end else begin
         state     <= state_n;
         dir_q     <= dir_n;
         tgt_valid <= tgt_valid_n;
         tgt_floor <= tgt_floor_n;
         clr_in    <= clr_in_n;
         clr_up    <= clr_up_n;
         clr_down  <= clr_down_n;
      end
   end

   assign dir = dir_q;

endmodule
